// File: rtl/si_nave_move_controller.sv
// Player ship position sequencer: synchronizes left/right buttons and steps a one-hot
// position on frame ticks with auto-repeat. Optional wrap-around via SI_NAVE_CONTROLLER_WRAP_EN.
module si_nave_move_controller #(
  parameter int          REPEAT_TICKS = 4,
  parameter logic [7:0]  INIT_POS     = 8'b00010000
) (
  input  logic       SI_NAVE_CONTROLLER_CLOCK_50,
  input  logic       SI_NAVE_CONTROLLER_RESET_InLow,
  input  logic       SI_NAVE_CONTROLLER_LEFT_IN,
  input  logic       SI_NAVE_CONTROLLER_RIGHT_IN,
  input  logic       SI_NAVE_CONTROLLER_TICK_IN,
  input  logic [1:0] SI_NAVE_CONTROLLER_IND_BUS_IN,
  output logic [7:0] SI_NAVE_CONTROLLER_BUS_OUT,
  output logic       SI_NAVE_CONTROLLER_MOVED_OUT,
  output logic [1:0] SI_NAVE_CONTROLLER_STATE_OUT
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam logic [3:0] RELOAD = 4'(REPEAT_TICKS - 1);

  state_t      state_reg;
  logic [7:0]  pos_reg;
  logic        moved_reg;
  logic        dir_left_reg;
  logic [3:0]  cnt_reg;
  logic        left_meta_reg, left_sync_reg;
  logic        right_meta_reg, right_sync_reg;

  logic        req_left, req_right, req_held;
  logic [7:0]  step_pos;
  logic        step_moved;

  // Button synchronizers: two flops per input
  always_ff @(posedge SI_NAVE_CONTROLLER_CLOCK_50 or negedge SI_NAVE_CONTROLLER_RESET_InLow) begin
    if (!SI_NAVE_CONTROLLER_RESET_InLow) begin
      left_meta_reg  <= 1'b0;
      left_sync_reg  <= 1'b0;
      right_meta_reg <= 1'b0;
      right_sync_reg <= 1'b0;
    end else begin
      left_meta_reg  <= SI_NAVE_CONTROLLER_LEFT_IN;
      left_sync_reg  <= left_meta_reg;
      right_meta_reg <= SI_NAVE_CONTROLLER_RIGHT_IN;
      right_sync_reg <= right_meta_reg;
    end
  end

  assign req_left  = left_sync_reg & ~right_sync_reg;
  assign req_right = right_sync_reg & ~left_sync_reg;
  assign req_held  = dir_left_reg ? req_left : req_right;

  // Candidate position for a move in the latched direction. Rotation equals the plain
  // shift whenever the comparator allows the move, and can never drop the one-hot bit.
  always_comb begin
    step_pos   = pos_reg;
    step_moved = 1'b0;
    if (dir_left_reg) begin
      if (SI_NAVE_CONTROLLER_IND_BUS_IN[1]) begin
        step_pos   = {pos_reg[6:0], pos_reg[7]};
        step_moved = 1'b1;
      end
`ifdef SI_NAVE_CONTROLLER_WRAP_EN
      else if (SI_NAVE_CONTROLLER_IND_BUS_IN != 2'b00) begin
        step_pos   = 8'b00000001;
        step_moved = 1'b1;
      end
`endif
    end else begin
      if (SI_NAVE_CONTROLLER_IND_BUS_IN[0]) begin
        step_pos   = {pos_reg[0], pos_reg[7:1]};
        step_moved = 1'b1;
      end
`ifdef SI_NAVE_CONTROLLER_WRAP_EN
      else if (SI_NAVE_CONTROLLER_IND_BUS_IN != 2'b00) begin
        step_pos   = 8'b10000000;
        step_moved = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge SI_NAVE_CONTROLLER_CLOCK_50 or negedge SI_NAVE_CONTROLLER_RESET_InLow) begin
    if (!SI_NAVE_CONTROLLER_RESET_InLow) begin
      state_reg    <= IDLE;
      pos_reg      <= INIT_POS;
      moved_reg    <= 1'b0;
      dir_left_reg <= 1'b0;
      cnt_reg      <= 4'd0;
    end else begin
      moved_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_left || req_right) begin
            dir_left_reg <= req_left;
            state_reg    <= PEND;
          end
        end
        // The request check comes first so a drop coinciding with a tick suppresses the move
        PEND: begin
          if (!req_held) begin
            state_reg <= IDLE;
          end else if (SI_NAVE_CONTROLLER_TICK_IN) begin
            pos_reg   <= step_pos;
            moved_reg <= step_moved;
            cnt_reg   <= RELOAD;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (!req_held) begin
            state_reg <= IDLE;
          end else if (SI_NAVE_CONTROLLER_TICK_IN) begin
            if (cnt_reg != 4'd0) begin
              cnt_reg <= cnt_reg - 4'd1;
            end else begin
              pos_reg   <= step_pos;
              moved_reg <= step_moved;
              cnt_reg   <= RELOAD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign SI_NAVE_CONTROLLER_BUS_OUT   = pos_reg;
  assign SI_NAVE_CONTROLLER_MOVED_OUT = moved_reg;
  assign SI_NAVE_CONTROLLER_STATE_OUT = state_reg;

endmodule

// File: tb/tb_si_nave_move_controller.sv
// Directed bench for si_nave_move_controller; the ship comparator is modelled from BUS_OUT.
// Expectations follow SI_NAVE_CONTROLLER_WRAP_EN when it is defined.
module tb_si_nave_move_controller;

  logic       clk;
  logic       rst_n;
  logic       left;
  logic       right;
  logic       tick;
  logic       ind_force;
  logic [1:0] ind;
  logic [7:0] bus;
  logic       moved;
  logic [1:0] state;

  int tests_run;
  int tests_failed;

  si_nave_move_controller #(
    .REPEAT_TICKS(4),
    .INIT_POS(8'b00010000)
  ) dut (
    .SI_NAVE_CONTROLLER_CLOCK_50   (clk),
    .SI_NAVE_CONTROLLER_RESET_InLow(rst_n),
    .SI_NAVE_CONTROLLER_LEFT_IN    (left),
    .SI_NAVE_CONTROLLER_RIGHT_IN   (right),
    .SI_NAVE_CONTROLLER_TICK_IN    (tick),
    .SI_NAVE_CONTROLLER_IND_BUS_IN (ind),
    .SI_NAVE_CONTROLLER_BUS_OUT    (bus),
    .SI_NAVE_CONTROLLER_MOVED_OUT  (moved),
    .SI_NAVE_CONTROLLER_STATE_OUT  (state)
  );

  // Comparator: bit1 = left allowed (not at bit7), bit0 = right allowed (not at bit0)
  assign ind = ind_force ? 2'b00 : {~bus[7], ~bus[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    left = 1'b0;
    right = 1'b0;
    tick = 1'b0;
    ind_force = 1'b0;
    clocks(2);
    rst_n = 1'b1;
    clocks(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    left = 1'b0;
    right = 1'b0;
    tick = 1'b0;
    ind_force = 1'b0;
    clocks(2);
    tests_run++;
    if (bus !== 8'b00010000 || moved !== 1'b0 || state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_active: bus=%b moved=%b state=%b, required 00010000/0/00", bus, moved, state);
    end
    rst_n = 1'b1;
    clocks(3);
    tests_run++;
    if (bus !== 8'b00010000 || moved !== 1'b0 || state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_release: bus=%b moved=%b state=%b, required 00010000/0/00", bus, moved, state);
    end
    $display("[TB] reset done bus=%b state=%b", bus, state);
  endtask

  // Ticks every 10 clocks; moves land on ticks 1, 5, 9, then the bit7 boundary on tick 13
  task automatic test_left_repeat();
    logic [7:0] exp_bus;
    logic       exp_moved;
    do_reset();
    left = 1'b1;
    clocks(3);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL left_pend: state=%b, required 01", state);
    end
    for (int k = 1; k <= 13; k++) begin
      clocks(9);
      tick_once();
      exp_bus   = (k < 5) ? 8'b00100000 : (k < 9) ? 8'b01000000 : 8'b10000000;
      exp_moved = (k == 1 || k == 5 || k == 9) ? 1'b1 : 1'b0;
`ifdef SI_NAVE_CONTROLLER_WRAP_EN
      if (k == 13) begin
        exp_bus   = 8'b00000001;
        exp_moved = 1'b1;
      end
`endif
      $display("[TB] left tick %0d bus=%b moved=%b state=%b", k, bus, moved, state);
      tests_run++;
      if (bus !== exp_bus || moved !== exp_moved || state !== 2'b10) begin
        tests_failed++;
        $display("FAIL left_tick%0d: bus=%b moved=%b state=%b, required %b/%b/10",
                 k, bus, moved, state, exp_bus, exp_moved);
      end
    end
    clocks(1);
    tests_run++;
    if (moved !== 1'b0) begin
      tests_failed++;
      $display("FAIL moved_single_cycle: moved=%b, required 0", moved);
    end
    left = 1'b0;
  endtask

  task automatic test_right_edge();
    logic [7:0] exp_bus;
    logic       exp_moved;
    do_reset();
    right = 1'b1;
    clocks(3);
    for (int k = 1; k <= 9; k++) begin
      clocks(3);
      tick_once();
    end
    tests_run++;
    if (bus !== 8'b00000010) begin
      tests_failed++;
      $display("FAIL right_setup: bus=%b, required 00000010", bus);
    end
    right = 1'b0;
    clocks(4);
    tests_run++;
    if (state !== 2'b00 || bus !== 8'b00000010) begin
      tests_failed++;
      $display("FAIL right_release: state=%b bus=%b, required 00/00000010", state, bus);
    end
    right = 1'b1;
    clocks(3);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL right_pend: state=%b, required 01", state);
    end
    tick_once();
    $display("[TB] right first tick bus=%b moved=%b", bus, moved);
    tests_run++;
    if (bus !== 8'b00000001 || moved !== 1'b1) begin
      tests_failed++;
      $display("FAIL right_first: bus=%b moved=%b, required 00000001/1", bus, moved);
    end
    for (int k = 2; k <= 5; k++) begin
      clocks(3);
      tick_once();
    end
`ifdef SI_NAVE_CONTROLLER_WRAP_EN
    exp_bus   = 8'b10000000;
    exp_moved = 1'b1;
`else
    exp_bus   = 8'b00000001;
    exp_moved = 1'b0;
`endif
    $display("[TB] right boundary tick bus=%b moved=%b", bus, moved);
    tests_run++;
    if (bus !== exp_bus || moved !== exp_moved || state !== 2'b10) begin
      tests_failed++;
      $display("FAIL right_boundary: bus=%b moved=%b state=%b, required %b/%b/10",
               bus, moved, state, exp_bus, exp_moved);
    end
    right = 1'b0;
  endtask

  task automatic test_both_buttons();
    do_reset();
    left = 1'b1;
    right = 1'b1;
    clocks(3);
    for (int k = 0; k < 20; k++) begin
      clocks(2);
      tick_once();
    end
    $display("[TB] both held bus=%b state=%b", bus, state);
    tests_run++;
    if (bus !== 8'b00010000 || state !== 2'b00) begin
      tests_failed++;
      $display("FAIL both_no_move: bus=%b state=%b, required 00010000/00", bus, state);
    end
    right = 1'b0;
    clocks(3);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL both_release_pend: state=%b, required 01", state);
    end
    tick_once();
    tests_run++;
    if (bus !== 8'b00100000 || moved !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_release_move: bus=%b moved=%b, required 00100000/1", bus, moved);
    end
    left = 1'b0;
  endtask

  // Illegal indicator blocks the move but the FSM still advances and reloads the counter
  task automatic test_ind_illegal();
    do_reset();
    left = 1'b1;
    clocks(3);
    ind_force = 1'b1;
    tick_once();
    ind_force = 1'b0;
    tests_run++;
    if (bus !== 8'b00010000 || moved !== 1'b0 || state !== 2'b10) begin
      tests_failed++;
      $display("FAIL ind00_block: bus=%b moved=%b state=%b, required 00010000/0/10", bus, moved, state);
    end
    for (int k = 2; k <= 5; k++) begin
      clocks(2);
      tick_once();
      tests_run++;
      if (bus !== ((k == 5) ? 8'b00100000 : 8'b00010000)) begin
        tests_failed++;
        $display("FAIL ind00_repeat%0d: bus=%b, required %b", k, bus,
                 (k == 5) ? 8'b00100000 : 8'b00010000);
      end
    end
    left = 1'b0;
  endtask

  // Synchronized request falls on the same edge that samples the tick
  task automatic test_drop_vs_tick();
    do_reset();
    left = 1'b1;
    clocks(3);
    left = 1'b0;
    clocks(2);
    tick_once();
    $display("[TB] drop with tick bus=%b state=%b", bus, state);
    tests_run++;
    if (bus !== 8'b00010000 || moved !== 1'b0 || state !== 2'b00) begin
      tests_failed++;
      $display("FAIL drop_wins: bus=%b moved=%b state=%b, required 00010000/0/00", bus, moved, state);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    left = 1'b1;
    clocks(3);
    tick_once();
    tests_run++;
    if (bus !== 8'b00100000) begin
      tests_failed++;
      $display("FAIL areset_premove: bus=%b, required 00100000", bus);
    end
    clocks(3);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus !== 8'b00010000 || state !== 2'b00 || moved !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_immediate: bus=%b state=%b moved=%b, required 00010000/00/0", bus, state, moved);
    end
    clocks(1);
    #2;
    rst_n = 1'b1;
    clocks(2);
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL areset_sync_delay: state=%b, required 00", state);
    end
    clocks(1);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL areset_rearm: state=%b, required 01", state);
    end
    tick_once();
    $display("[TB] post-reset tick bus=%b moved=%b", bus, moved);
    tests_run++;
    if (bus !== 8'b00100000 || moved !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_move: bus=%b moved=%b, required 00100000/1", bus, moved);
    end
    left = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    left = 1'b0;
    right = 1'b0;
    tick = 1'b0;
    ind_force = 1'b0;
    test_reset();
    test_left_repeat();
    test_right_edge();
    test_both_buttons();
    test_ind_illegal();
    test_drop_vs_tick();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/si_nave_move_controller.md
Name: si_nave_move_controller

Overview:
- Sequences the player ship ("nave") position register in response to left/right buttons, paced by a frame tick.
- The 8-bit one-hot position drives the ship comparator. The comparator's 2-bit boundary indicator comes back to this block and gates every move.
- Sits between the button input logic and the ship render/compare datapath.

Parameters:
- REPEAT_TICKS, 4: frame ticks between auto-repeat moves while a button is held. Legal range 1..15.
- INIT_POS, 8'b00010000: one-hot position loaded at reset.

Ports:
- SI_NAVE_CONTROLLER_CLOCK_50  in  1  system clock; all state on rising edge.
- SI_NAVE_CONTROLLER_RESET_InLow  in  1  asynchronous, active-low reset.
- SI_NAVE_CONTROLLER_LEFT_IN  in  1  left button, active-high, asynchronous to clock.
- SI_NAVE_CONTROLLER_RIGHT_IN  in  1  right button, active-high, asynchronous to clock.
- SI_NAVE_CONTROLLER_TICK_IN  in  1  frame tick, one-clock pulse, synchronous.
- SI_NAVE_CONTROLLER_IND_BUS_IN  in  2  comparator indicator for the current BUS_OUT.
  - Bit1 = left move allowed; bit0 = right move allowed.
  - 10 = at bit0; 01 = at bit7; 11 = interior.
- SI_NAVE_CONTROLLER_BUS_OUT  out  8  one-hot ship position, registered.
- SI_NAVE_CONTROLLER_MOVED_OUT  out  1  one-clock pulse in the cycle after the position changed.
- SI_NAVE_CONTROLLER_STATE_OUT  out  2  current FSM state, for debug.

Behaviour:
- Reset (RESET_InLow=0, asynchronous):
  - BUS_OUT=INIT_POS, MOVED_OUT=0, STATE=IDLE, repeat counter=0.
  - Synchronizer flops cleared to 0.
  - Deassertion mid-press: button is first seen 2 clocks later and treated as a new press.
- Input synchronization: LEFT/RIGHT each pass through a 2-flop synchronizer, giving 2-clock latency.
- Direction decode, from synchronized levels only:
  - L = left & ~right; R = right & ~left.
  - Both or neither asserted = no request.
- Move rules:
  - Left = position << 1, taken only if IND bit1=1.
  - Right = position >> 1, taken only if IND bit0=1.
  - A blocked move leaves BUS_OUT unchanged, gives no MOVED pulse, and still follows the same state transitions as a taken move.
  - IND=00 (illegal) blocks both directions.
- FSM states (encodings): IDLE=00, PEND=01, HOLD=10.
  - IDLE: on L or R, latch the direction and go to PEND. Otherwise stay.
  - PEND: on TICK_IN, attempt a move in the latched direction, load counter=REPEAT_TICKS-1, go to HOLD.
  - PEND, request drops or changes direction before a tick: return to IDLE, no move.
  - HOLD, request drops or changes direction: go to IDLE the next clock. IDLE re-arms with the new direction one clock later.
  - HOLD, TICK_IN with counter>0: decrement the counter.
  - HOLD, TICK_IN with counter==0: attempt a move and reload counter=REPEAT_TICKS-1.
- Timing:
  - The move takes effect on the clock edge where TICK_IN=1 is sampled.
  - MOVED_OUT is high in the following cycle.
  - At most one move per tick; first move lands on the first tick after the press.
- IND timing: IND_BUS_IN is combinational from BUS_OUT, so it is valid in every cycle. The controller samples it only in the move cycle.
- BUS_OUT stays one-hot at all times.
- Simultaneous TICK and request drop: the drop wins and no move occurs. Request is evaluated before the tick in every state.

Optional Feature:
- Macro: SI_NAVE_CONTROLLER_WRAP_EN.
- Defined:
  - A blocked move wraps instead of stalling: left at bit7 yields 8'b00000001; right at bit0 yields 8'b10000000.
  - MOVED_OUT pulses on a wrap.
  - IND=00 still blocks both directions.
- Undefined: blocked moves stall as described in Behaviour.

Test Plan:
- Reset, with or without active clock → BUS_OUT=8'b00010000, MOVED_OUT=0, STATE=00. Release reset → values hold.
- Press LEFT, tick every 10 clocks, REPEAT_TICKS=4:
  - First tick → 8'b00100000 plus a MOVED pulse.
  - Next moves on the 5th and 9th ticks → 8'b01000000, then 8'b10000000.
- Hold LEFT with BUS_OUT=8'b10000000 (IND=01):
  - Without WRAP_EN → BUS_OUT unchanged, no MOVED pulse, STATE stays 10.
  - With WRAP_EN → BUS_OUT=8'b00000001 plus a MOVED pulse.
- Press RIGHT at 8'b00000010 → first tick gives 8'b00000001. Later ticks blocked (IND=10), BUS_OUT stays 8'b00000001.
- Assert LEFT and RIGHT together for 20 ticks → no move, STATE=00. Release RIGHT → PEND, then a left move on the next tick.
- Press LEFT, assert reset asynchronously between ticks → BUS_OUT immediately 8'b00010000. After release, with LEFT still held → move to 8'b00100000 on the first tick after the 2-clock synchronizer delay.
